// File: rtl/ao_periph_bridge_pkg.sv
// Shared definitions for the always-on peripheral OBI timeout bridge.
package ao_periph_bridge_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StIssue   = 2'd1,
      StWaitR   = 2'd2,
      StErrResp = 2'd3
   } bridge_state_e;

   localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADC0FFE;
   localparam int unsigned CNT_W             = 16;

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by the system bus and its peripheral bridges.
package obi_pkg;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;

endpackage

// File: rtl/ao_periph_obi_timeout_bridge.sv
// Single-outstanding OBI bridge in front of the always-on peripheral subsystem.
// A transaction that stalls downstream is completed upstream with an error read
// value; a response that is still owed downstream is drained before new traffic.
module ao_periph_obi_timeout_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ERR_RDATA      = ao_periph_bridge_pkg::ERR_RDATA_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  obi_pkg::obi_req_t  slave_req_i,
   output obi_pkg::obi_resp_t slave_resp_o,
   output obi_pkg::obi_req_t  master_req_o,
   input  obi_pkg::obi_resp_t master_resp_i,
   input  logic              clear_i,
   output logic              timeout_pulse_o,
   output logic [7:0]        timeout_count_o
);
   import ao_periph_bridge_pkg::*;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 32'd1);

   bridge_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             drain_q, drain_d;
   logic [7:0]       tcount_q, tcount_d;
   logic             timeout;
   logic             capture;

   logic [31:0]      addr_q;
   logic             we_q;
   logic [3:0]       be_q;
   logic [31:0]      wdata_q;

   // Next-state, counter, drain and bus output decode.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      drain_d      = drain_q;
      timeout      = 1'b0;
      capture      = 1'b0;
      slave_resp_o = '0;
      master_req_o = '0;

      unique case (state_q)
         StIdle: begin
            if (!drain_q) begin
               slave_resp_o.gnt = slave_req_i.req;
               if (slave_req_i.req) begin
                  capture = 1'b1;
                  cnt_d   = '0;
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            master_req_o.req   = 1'b1;
            master_req_o.addr  = addr_q;
            master_req_o.we    = we_q;
            master_req_o.be    = be_q;
            master_req_o.wdata = wdata_q;
            cnt_d              = cnt_q + 1'b1;
            if (master_resp_i.gnt) begin
               state_d = StWaitR;
            end else if (cnt_q == LAST_CNT) begin
               timeout = 1'b1;
               state_d = StErrResp;
            end
         end
         StWaitR: begin
            cnt_d = cnt_q + 1'b1;
            if (master_resp_i.rvalid) begin
               slave_resp_o.rvalid = 1'b1;
               slave_resp_o.rdata  = master_resp_i.rdata;
               state_d             = StIdle;
            end else if (cnt_q >= LAST_CNT) begin
               // >= covers a grant taken in the last ISSUE cycle, which leaves the
               // counter one past the limit on the first WAIT_R cycle.
               timeout = 1'b1;
               drain_d = 1'b1;
               cnt_d   = '0;
               state_d = StErrResp;
            end
         end
         StErrResp: begin
            slave_resp_o.rvalid = 1'b1;
            slave_resp_o.rdata  = ERR_RDATA;
            state_d             = StIdle;
         end
      endcase

      // Drain only runs in ERR_RESP/IDLE, where the counter is otherwise unused.
      if (drain_q) begin
         if (master_resp_i.rvalid || (cnt_q >= LAST_CNT)) begin
            drain_d = 1'b0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      if (clear_i) begin
         drain_d = 1'b0;
      end

      tcount_d = clear_i ? 8'd0 : tcount_q;
      if (timeout && (tcount_d != 8'hFF)) begin
         tcount_d = tcount_d + 8'd1;
      end

      timeout_pulse_o = (state_q == StErrResp);
      timeout_count_o = tcount_q;
   end

   // Control state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         drain_q  <= 1'b0;
         tcount_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         drain_q  <= drain_d;
         tcount_q <= tcount_d;
      end
   end

   // Request fields latched at the upstream grant and replayed downstream.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
      end else if (capture) begin
         addr_q  <= slave_req_i.addr;
         we_q    <= slave_req_i.we;
         be_q    <= slave_req_i.be;
         wdata_q <= slave_req_i.wdata;
      end
   end

endmodule

// File: tb/tb_ao_periph_obi_timeout_bridge.sv
// Directed bench for ao_periph_obi_timeout_bridge with TIMEOUT_CYCLES = 8.
// Cycle n starts at a rising edge; inputs change 1 time unit later and outputs
// are sampled at the following falling edge.
module tb_ao_periph_obi_timeout_bridge;
   import obi_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   obi_req_t   sreq;
   obi_resp_t  sresp;
   obi_req_t   mreq;
   obi_resp_t  mresp;
   logic       pulse;
   logic [7:0] tcnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ao_periph_obi_timeout_bridge #(
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .slave_req_i    (sreq),
      .slave_resp_o   (sresp),
      .master_req_o   (mreq),
      .master_resp_i  (mresp),
      .clear_i        (clear),
      .timeout_pulse_o(pulse),
      .timeout_count_o(tcnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   // Drive a request in a fresh cycle and sample that same cycle.
   task automatic start_req(input logic [31:0] a, input logic w, input logic [31:0] d);
      step();
      sreq.req   = 1'b1;
      sreq.addr  = a;
      sreq.we    = w;
      sreq.be    = 4'hF;
      sreq.wdata = d;
      samp();
   endtask

   // Finish a granted transaction: downstream gnt, then rvalid, then idle.
   task automatic complete_txn(input logic [31:0] d);
      step();
      sreq.req   = 1'b0;
      mresp.gnt  = 1'b1;
      step();
      mresp.gnt    = 1'b0;
      mresp.rvalid = 1'b1;
      mresp.rdata  = d;
      step();
      mresp = '0;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (sresp !== '0) begin n_err++; $display("FAIL rst_sresp got %h want 0", sresp); end
      n_cmp++; if (mreq !== '0) begin n_err++; $display("FAIL rst_mreq got %h want 0", mreq); end
      n_cmp++; if (pulse !== 1'b0) begin n_err++; $display("FAIL rst_pulse got %b want 0", pulse); end
      n_cmp++; if (tcnt !== 8'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", tcnt); end
      #10 rst_n = 1'b1;
   endtask

   task automatic test_read_basic();
      start_req(32'h2000_0000, 1'b0, 32'h0);
      n_cmp++; if (sresp.gnt !== 1'b1) begin n_err++; $display("FAIL rd_gnt got %b want 1", sresp.gnt); end
      step(); sreq.req = 1'b0; mresp.gnt = 1'b1; samp();
      n_cmp++; if ({mreq.req, mreq.addr, mreq.we} !== {1'b1, 32'h2000_0000, 1'b0}) begin
         n_err++; $display("FAIL rd_mreq got %b/%h/%b want 1/20000000/0", mreq.req, mreq.addr, mreq.we);
      end
      step(); mresp.gnt = 1'b0; samp();
      n_cmp++; if (sresp.rvalid !== 1'b0) begin n_err++; $display("FAIL rd_early_rvalid got %b want 0", sresp.rvalid); end
      step(); mresp.rvalid = 1'b1; mresp.rdata = 32'h1234_5678; samp();
      n_cmp++; if ({sresp.rvalid, sresp.rdata} !== {1'b1, 32'h1234_5678}) begin
         n_err++; $display("FAIL rd_data got %b/%h want 1/12345678", sresp.rvalid, sresp.rdata);
      end
      n_cmp++; if (pulse !== 1'b0) begin n_err++; $display("FAIL rd_pulse got %b want 0", pulse); end
      step(); mresp = '0; samp();
      n_cmp++; if (sresp !== '0) begin n_err++; $display("FAIL rd_after got %h want 0", sresp); end
      n_cmp++; if (tcnt !== 8'd0) begin n_err++; $display("FAIL rd_count got %0d want 0", tcnt); end
   endtask

   task automatic test_timeout_issue();
      start_req(32'h2000_0040, 1'b1, 32'hCAFE_F00D);
      n_cmp++; if (sresp.gnt !== 1'b1) begin n_err++; $display("FAIL ti_gnt got %b want 1", sresp.gnt); end
      for (int c = 1; c <= 8; c++) begin
         step(); sreq.req = 1'b0; samp();
         n_cmp++; if ({mreq.req, mreq.wdata} !== {1'b1, 32'hCAFE_F00D}) begin
            n_err++; $display("FAIL ti_hold c%0d got %b/%h want 1/cafef00d", c, mreq.req, mreq.wdata);
         end
      end
      step(); samp();
      n_cmp++; if (mreq.req !== 1'b0) begin n_err++; $display("FAIL ti_req_drop got %b want 0", mreq.req); end
      n_cmp++; if ({sresp.rvalid, sresp.rdata} !== {1'b1, 32'hBADC_0FFE}) begin
         n_err++; $display("FAIL ti_err got %b/%h want 1/badc0ffe", sresp.rvalid, sresp.rdata);
      end
      n_cmp++; if (pulse !== 1'b1) begin n_err++; $display("FAIL ti_pulse got %b want 1", pulse); end
      start_req(32'h2000_0004, 1'b0, 32'h0);
      n_cmp++; if (sresp.gnt !== 1'b1) begin n_err++; $display("FAIL ti_next_gnt got %b want 1", sresp.gnt); end
      n_cmp++; if ({pulse, sresp.rvalid} !== 2'b00) begin
         n_err++; $display("FAIL ti_next_quiet got %b%b want 00", pulse, sresp.rvalid);
      end
      n_cmp++; if (tcnt !== 8'd1) begin n_err++; $display("FAIL ti_count got %0d want 1", tcnt); end
      complete_txn(32'h0);
   endtask

   task automatic test_drain_late_rvalid();
      start_req(32'h2000_0100, 1'b0, 32'h0);
      step(); sreq.req = 1'b0; mresp.gnt = 1'b1;
      for (int c = 2; c <= 8; c++) begin
         step(); mresp.gnt = 1'b0;
      end
      step(); sreq.req = 1'b1; samp();
      n_cmp++; if ({sresp.gnt, sresp.rvalid, sresp.rdata} !== {2'b01, 32'hBADC_0FFE}) begin
         n_err++; $display("FAIL dl_err got %b%b/%h want 01/badc0ffe", sresp.gnt, sresp.rvalid, sresp.rdata);
      end
      for (int c = 10; c <= 11; c++) begin
         step(); samp();
         n_cmp++; if (sresp.gnt !== 1'b0) begin n_err++; $display("FAIL dl_block c%0d got %b want 0", c, sresp.gnt); end
      end
      step(); mresp.rvalid = 1'b1; mresp.rdata = 32'hAAAA_AAAA; samp();
      n_cmp++; if (sresp !== '0) begin n_err++; $display("FAIL dl_discard got %h want 0", sresp); end
      step(); mresp = '0; samp();
      n_cmp++; if (sresp.gnt !== 1'b1) begin n_err++; $display("FAIL dl_resume got %b want 1", sresp.gnt); end
      n_cmp++; if (tcnt !== 8'd2) begin n_err++; $display("FAIL dl_count got %0d want 2", tcnt); end
      complete_txn(32'h600D_600D);
   endtask

   task automatic test_drain_expiry();
      start_req(32'h2000_0200, 1'b0, 32'h0);
      step(); sreq.req = 1'b0; mresp.gnt = 1'b1;
      for (int c = 2; c <= 8; c++) begin
         step(); mresp.gnt = 1'b0;
      end
      step(); sreq.req = 1'b1;
      for (int c = 10; c <= 16; c++) begin
         step(); samp();
         n_cmp++; if (sresp.gnt !== 1'b0) begin n_err++; $display("FAIL de_block c%0d got %b want 0", c, sresp.gnt); end
      end
      step(); samp();
      n_cmp++; if (sresp.gnt !== 1'b1) begin n_err++; $display("FAIL de_resume got %b want 1", sresp.gnt); end
      n_cmp++; if (tcnt !== 8'd3) begin n_err++; $display("FAIL de_count got %0d want 3", tcnt); end
      complete_txn(32'h0);
   endtask

   task automatic test_race_at_timeout();
      // rvalid in the last WAIT_R cycle
      start_req(32'h2000_0300, 1'b0, 32'h0);
      step(); sreq.req = 1'b0; mresp.gnt = 1'b1;
      for (int c = 2; c <= 7; c++) begin
         step(); mresp.gnt = 1'b0;
      end
      step(); mresp.rvalid = 1'b1; mresp.rdata = 32'h5A5A_5A5A; samp();
      n_cmp++; if ({sresp.rvalid, sresp.rdata} !== {1'b1, 32'h5A5A_5A5A}) begin
         n_err++; $display("FAIL rv_race got %b/%h want 1/5a5a5a5a", sresp.rvalid, sresp.rdata);
      end
      n_cmp++; if (pulse !== 1'b0) begin n_err++; $display("FAIL rv_race_pulse got %b want 0", pulse); end
      step(); mresp = '0; samp();
      n_cmp++; if ({pulse, sresp.rvalid} !== 2'b00) begin
         n_err++; $display("FAIL rv_race_after got %b%b want 00", pulse, sresp.rvalid);
      end
      n_cmp++; if (tcnt !== 8'd3) begin n_err++; $display("FAIL rv_race_count got %0d want 3", tcnt); end
      // gnt in the last ISSUE cycle
      start_req(32'h2000_0304, 1'b0, 32'h0);
      n_cmp++; if (sresp.gnt !== 1'b1) begin n_err++; $display("FAIL gn_race_gnt got %b want 1", sresp.gnt); end
      for (int c = 1; c <= 7; c++) begin
         step(); sreq.req = 1'b0;
      end
      step(); mresp.gnt = 1'b1; samp();
      n_cmp++; if (mreq.req !== 1'b1) begin n_err++; $display("FAIL gn_race_req got %b want 1", mreq.req); end
      step(); mresp.gnt = 1'b0; mresp.rvalid = 1'b1; mresp.rdata = 32'h7777_1111; samp();
      n_cmp++; if ({sresp.rvalid, sresp.rdata, pulse} !== {1'b1, 32'h7777_1111, 1'b0}) begin
         n_err++; $display("FAIL gn_race got %b/%h/%b want 1/77771111/0", sresp.rvalid, sresp.rdata, pulse);
      end
      step(); mresp = '0; samp();
      n_cmp++; if (tcnt !== 8'd3) begin n_err++; $display("FAIL gn_race_count got %0d want 3", tcnt); end
   endtask

   task automatic test_saturate_clear();
      // Back-to-back ISSUE timeouts: 10 cycles each, 300 in total.
      step(); sreq.req = 1'b1; sreq.we = 1'b0;
      repeat (3000) @(posedge clk);
      #1 sreq.req = 1'b0;
      step(); samp();
      n_cmp++; if (tcnt !== 8'd255) begin n_err++; $display("FAIL sat_count got %0d want 255", tcnt); end
      step(); clear = 1'b1;
      step(); clear = 1'b0; samp();
      n_cmp++; if (tcnt !== 8'd0) begin n_err++; $display("FAIL sat_clear got %0d want 0", tcnt); end
      start_req(32'h2000_0400, 1'b0, 32'h0);
      for (int c = 1; c <= 9; c++) begin
         step(); sreq.req = 1'b0;
      end
      samp();
      n_cmp++; if (tcnt !== 8'd1) begin n_err++; $display("FAIL sat_one got %0d want 1", tcnt); end
      // clear coincides with the timeout cycle
      start_req(32'h2000_0404, 1'b0, 32'h0);
      for (int c = 1; c <= 7; c++) begin
         step(); sreq.req = 1'b0;
      end
      step(); clear = 1'b1;
      step(); clear = 1'b0; samp();
      n_cmp++; if ({pulse, tcnt} !== {1'b1, 8'd1}) begin
         n_err++; $display("FAIL clr_race got %b/%0d want 1/1", pulse, tcnt);
      end
   endtask

   task automatic test_reset_wait_r();
      start_req(32'h2000_0500, 1'b0, 32'h0);
      step(); sreq.req = 1'b0; mresp.gnt = 1'b1;
      step(); mresp.gnt = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (sresp !== '0) begin n_err++; $display("FAIL rw_sresp got %h want 0", sresp); end
      n_cmp++; if (mreq !== '0) begin n_err++; $display("FAIL rw_mreq got %h want 0", mreq); end
      n_cmp++; if ({pulse, tcnt} !== 9'd0) begin n_err++; $display("FAIL rw_count got %b/%0d want 0/0", pulse, tcnt); end
      step(); rst_n = 1'b1;
      step(); mresp.rvalid = 1'b1; mresp.rdata = 32'hDEAD_BEEF; samp();
      n_cmp++; if (sresp !== '0) begin n_err++; $display("FAIL rw_stale got %h want 0", sresp); end
      for (int c = 0; c < 3; c++) begin
         step(); mresp = '0; samp();
         n_cmp++; if (sresp.rvalid !== 1'b0) begin n_err++; $display("FAIL rw_quiet c%0d got %b want 0", c, sresp.rvalid); end
      end
      start_req(32'h2000_0504, 1'b0, 32'h0);
      n_cmp++; if (sresp.gnt !== 1'b1) begin n_err++; $display("FAIL rw_gnt got %b want 1", sresp.gnt); end
      complete_txn(32'h0);
   endtask

   initial begin
      sreq  = '0;
      mresp = '0;
      test_reset();
      test_read_basic();
      test_timeout_issue();
      test_drain_late_rvalid();
      test_drain_expiry();
      test_race_at_timeout();
      test_saturate_clear();
      test_reset_wait_r();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1);
   end

endmodule

// File: doc/ao_periph_obi_timeout_bridge.md
AO_PERIPH_OBI_TIMEOUT_BRIDGE -- requirements
Module: ao_periph_obi_timeout_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256: max cycles a transaction may remain outstanding downstream (range 2..65535).
REQ-002 SHALL have parameter ERR_RDATA, default 32'hBADC0FFE: read data returned on a timed-out transaction.
REQ-003 SHALL have port clk_i, input, 1: the single clock.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port slave_req_i, input, obi_pkg::obi_req_t: request from the system bus.
REQ-006 SHALL have port slave_resp_o, output, obi_pkg::obi_resp_t: response to the system bus.
REQ-007 SHALL have port master_req_o, output, obi_pkg::obi_req_t: request to the always-on peripheral subsystem slave port.
REQ-008 SHALL have port master_resp_i, input, obi_pkg::obi_resp_t: response from the always-on peripheral subsystem.
REQ-009 SHALL have port clear_i, input, 1: synchronous clear of timeout_count_o and the drain flag.
REQ-010 SHALL have port timeout_pulse_o, output, 1: one-cycle pulse per timeout event.
REQ-011 SHALL have port timeout_count_o, output, 8: saturating count of timeouts.

Function
REQ-012 SHALL implement a state machine with states IDLE, ISSUE, WAIT_R and ERR_RESP, allowing one outstanding transaction.
REQ-013 In IDLE with drain clear, SHALL assert slave_resp_o.gnt combinationally when slave_req_i.req=1, capture addr/we/be/wdata into registers, and move to ISSUE.
REQ-014 In IDLE with drain set, SHALL hold slave_resp_o.gnt=0.
REQ-015 In ISSUE, SHALL drive master_req_o.req=1 with the captured fields held stable, and SHALL move to WAIT_R on master_resp_i.gnt=1.
REQ-016 In WAIT_R, on master_resp_i.rvalid=1, SHALL pass rvalid=1 and rdata through to slave_resp_o in the same cycle and return to IDLE.
REQ-017 Minimum latency SHALL be: slave gnt at cycle 0, master req at cycle 1, slave rvalid in the cycle of master rvalid (at least cycle 2).
REQ-018 SHALL clear a 16-bit cycle counter on entry to ISSUE and increment it each cycle in ISSUE or WAIT_R.
REQ-019 A timeout event SHALL occur when the counter equals TIMEOUT_CYCLES-1 and no completing event occurs in that cycle; the next state is then ERR_RESP.
REQ-020 In a simultaneous gnt-and-timeout cycle (ISSUE), the gnt SHALL win; in a simultaneous rvalid-and-timeout cycle (WAIT_R), the rvalid SHALL win, and no timeout is recorded.
REQ-021 A timeout in ISSUE SHALL deassert master_req_o.req from the next cycle on and SHALL NOT set drain.
REQ-022 A timeout in WAIT_R SHALL set the drain flag.
REQ-023 In ERR_RESP, for exactly one cycle, SHALL drive slave_resp_o.rvalid=1 and rdata=ERR_RDATA (for writes as well), then return to IDLE.
REQ-024 SHALL assert timeout_pulse_o in the ERR_RESP cycle and increment timeout_count_o, saturating at 255.
REQ-025 While drain is set, SHALL discard a master_resp_i.rvalid (never forwarded) and clear drain.
REQ-026 Drain SHALL also clear after TIMEOUT_CYCLES cycles without that rvalid, or on clear_i.
REQ-027 clear_i SHALL zero timeout_count_o; a clear and a timeout in the same cycle SHALL yield count 1.
REQ-028 slave_resp_o.rvalid SHALL be 0 outside REQ-016 and REQ-023; master_req_o.req SHALL be 0 outside ISSUE.
REQ-029 slave_resp_o.rdata SHALL be 0 when rvalid=0.

Reset
REQ-030 Asserting rst_ni SHALL immediately force state=IDLE, counter=0, drain=0, timeout_count_o=0, timeout_pulse_o=0, master_req_o all-zero, and slave_resp_o all-zero.
REQ-031 Reset mid-transaction SHALL abandon the transaction without producing any response.

Structure
REQ-032 The state enum and the ERR_RDATA default SHALL reside in shared package ao_periph_bridge_pkg; the obi types SHALL come from obi_pkg.
REQ-033 The block SHALL be a single module with no sub-modules, and SHALL be placed between the bus slave port and ao_peripheral_subsystem.slave_req_i.

Verification
REQ-034 Read to 0x2000_0000; downstream gnt at cycle 1 and rvalid at cycle 3 with 0x1234_5678 -> slave rvalid at cycle 3 with 0x1234_5678; no pulse.
REQ-035 TIMEOUT_CYCLES=8, downstream never grants -> master req drops after 8 cycles; slave rvalid next cycle with 0xBADC0FFE; count=1; the next request is granted immediately.
REQ-036 TIMEOUT_CYCLES=8, gnt without rvalid; a late rvalid 0xAAAA_AAAA arrives 3 cycles after the error response -> the late rvalid is not forwarded; gnt is blocked until it arrives, then resumes.
REQ-037 Rvalid arrives in the exact timeout cycle -> data is forwarded, no timeout_pulse_o, count unchanged.
REQ-038 Force 300 timeouts -> timeout_count_o=255; then clear_i -> 0.
REQ-039 Reset asserted in WAIT_R -> all outputs are 0 asynchronously; no response after release.
